// File: rtl/axi_slave6_mem_responder.sv
// AXI4 Slave 6 responder with a 4 KB memory. First wready/rvalid is 1 cycle after the address handshake, and bvalid is 1 cycle after the last W beat.
// B and R are held until bready/rready. Define AXI_S6_READY_STALL_EN to add LFSR-driven stalls on awready/wready/arready.
module axi_slave6_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_C000,
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ID_W      = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);
    localparam int unsigned AB     = $clog2(MEM_BYTES);
    localparam int unsigned IW     = (AB > 2) ? AB - 2 : 1;
    localparam int unsigned WORDS  = MEM_BYTES / 4;
    localparam logic [31:0] MEM_SZ = 32'(MEM_BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic f_in_range(input logic [31:0] addr);
        return (addr - BASE_ADDR) < MEM_SZ;
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE_ADDR) >> 2;
        return IW'(off);
    endfunction

    function automatic logic f_static_err(input logic [2:0] size, input logic [7:0] len,
                                          input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || bad_wrap;
    endfunction

    // DECERR outranks SLVERR, so the numeric max of codes is the worst error.
    function automatic logic [1:0] f_resp(input logic [31:0] addr, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] burst,
                                          input logic extra_err);
        if (!f_in_range(addr))                         return 2'b11;
        else if (f_static_err(size, len, burst) || extra_err) return 2'b10;
        else                                           return 2'b00;
    endfunction

    function automatic logic [31:0] f_next(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] beat, bound;
        beat  = 32'd1 << size;
        bound = ({24'd0, len} + 32'd1) << size;
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~(bound - 32'd1)) | ((addr + beat) & (bound - 32'd1));
            default: return addr + beat;
        endcase
    endfunction

    logic [31:0] r_mem [WORDS];
    logic        r_live;
    logic        w_stall;

`ifdef AXI_S6_READY_STALL_EN
    logic [7:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (!rstn) r_lfsr <= 8'hA5;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Keeps every ready low while reset is held and for the first cycle after release.
    always_ff @(posedge clk) begin
        if (!rstn) r_live <= 1'b0;
        else       r_live <= 1'b1;
    end

    // ---------------- write path ----------------
    wstate_t         r_wstate, w_wstate_nxt;
    logic [ID_W-1:0] r_awid;
    logic [31:0]     r_awaddr;
    logic [7:0]      r_awlen, r_wcnt;
    logic [2:0]      r_awsize;
    logic [1:0]      r_awburst, r_bresp, w_wbeat_resp;
    logic            w_awready, w_wready, w_aw_hs, w_w_hs, w_wfinal, w_mem_we;

    assign w_awready    = r_live && (r_wstate == W_IDLE) && !w_stall;
    assign w_wready     = r_live && (r_wstate == W_DATA) && !w_stall;
    assign w_aw_hs      = awvalid && w_awready;
    assign w_w_hs       = wvalid && w_wready;
    assign w_wfinal     = (r_wcnt == r_awlen);
    assign w_wbeat_resp = f_resp(r_awaddr, r_awsize, r_awlen, r_awburst, wlast != w_wfinal);
    assign w_mem_we     = w_w_hs && rstn && (w_wbeat_resp == 2'b00);

    always_ff @(posedge clk) begin
        if (!rstn) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_aw_hs)             w_wstate_nxt = W_DATA;
            W_DATA: if (w_w_hs && w_wfinal)  w_wstate_nxt = W_RESP;
            W_RESP: if (bready)              w_wstate_nxt = W_IDLE;
            default:                         w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
            r_bresp   <= '0;
        end else if (w_aw_hs) begin
            r_awid    <= awid;
            r_awaddr  <= awaddr;
            r_awlen   <= awlen;
            r_awsize  <= awsize;
            r_awburst <= awburst;
            r_wcnt    <= '0;
            r_bresp   <= '0;
        end else if (w_w_hs) begin
            r_awaddr <= f_next(r_awaddr, r_awsize, r_awlen, r_awburst);
            r_wcnt   <= r_wcnt + 8'd1;
            if (w_wbeat_resp > r_bresp) r_bresp <= w_wbeat_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) r_mem[f_idx(r_awaddr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t         r_rstate, w_rstate_nxt;
    logic [ID_W-1:0] r_arid;
    logic [31:0]     r_araddr, r_rdata, w_rd_addr, w_rd_word;
    logic [7:0]      r_arlen, r_rcnt;
    logic [2:0]      r_arsize;
    logic [1:0]      r_arburst, r_rresp, w_rd_resp;
    logic            r_rlast, w_arready, w_ar_hs, w_r_hs;

    assign w_arready = r_live && (r_rstate == R_IDLE) && !w_stall;
    assign w_ar_hs   = arvalid && w_arready;
    assign w_r_hs    = (r_rstate == R_DATA) && rready;

    // Beat data is captured into registers so it stays stable under backpressure.
    assign w_rd_addr = w_ar_hs ? araddr : f_next(r_araddr, r_arsize, r_arlen, r_arburst);
    assign w_rd_resp = w_ar_hs ? f_resp(araddr, arsize, arlen, arburst, 1'b0)
                               : f_resp(w_rd_addr, r_arsize, r_arlen, r_arburst, 1'b0);
    assign w_rd_word = f_in_range(w_rd_addr) ? r_mem[f_idx(w_rd_addr)] : 32'd0;

    always_ff @(posedge clk) begin
        if (!rstn) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)           w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
            default:                        w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
        end else if (w_ar_hs) begin
            r_arid    <= arid;
            r_araddr  <= araddr;
            r_arlen   <= arlen;
            r_arsize  <= arsize;
            r_arburst <= arburst;
            r_rcnt    <= '0;
            r_rdata   <= w_rd_word;
            r_rresp   <= w_rd_resp;
            r_rlast   <= (arlen == 8'd0);
        end else if (w_r_hs && !r_rlast) begin
            r_araddr <= w_rd_addr;
            r_rcnt   <= r_rcnt + 8'd1;
            r_rdata  <= w_rd_word;
            r_rresp  <= w_rd_resp;
            r_rlast  <= ((r_rcnt + 8'd1) == r_arlen);
        end
    end

    assign awready = w_awready;
    assign wready  = w_wready;
    assign bvalid  = (r_wstate == W_RESP);
    assign bid     = r_awid;
    assign bresp   = r_bresp;
    assign arready = w_arready;
    assign rvalid  = (r_rstate == R_DATA);
    assign rid     = r_arid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule
